sid_spi_burst_rx: RTL and testbench

Parametrised SPI-slave write receiver feeding the SID register files. It oversamples an external SPI bus (mode 0, MSB first) on the system clock and decodes each `ss`-framed transaction into a command word followed by one or more data words. It emits single-cycle register-write strobes carrying a channel select, address and data, which lets one SPI link drive several SID register banks. It supports auto-increment bursts, fixed-address streaming and framing-error reporting.

---
 rtl/sid_spi_burst_rx_if.sv | 27 ++
 rtl/sid_spi_burst_rx.sv | 156 +++++++++++++++
 tb/tb_sid_spi_burst_rx.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/sid_spi_burst_rx_if.sv
// Bus bundle for sid_spi_burst_rx: raw SPI inputs plus the register-write strobe side.
// The slave modport is the receiver's view; master is whoever drives the SPI pins.
interface sid_spi_burst_rx_if #(
  parameter int CHAN_W = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              ss;
  logic              sclk;
  logic              mosi;
  logic              wr_en;
  logic [CHAN_W-1:0] wr_chan;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              frame_err;
  logic              busy;

  modport slave (
    input  ss, sclk, mosi,
    output wr_en, wr_chan, wr_addr, wr_data, frame_err, busy
  );

  modport master (
    output ss, sclk, mosi,
    input  wr_en, wr_chan, wr_addr, wr_data, frame_err, busy
  );
endinterface

// File: rtl/sid_spi_burst_rx.sv
// Oversampling SPI-slave (mode 0, MSB first) write receiver: a command word selects
// channel/address/auto-increment, then each following data word becomes a write strobe.
module sid_spi_burst_rx #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int CHAN_W   = 2,
  parameter int CHANNELS = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  sid_spi_burst_rx_if.slave     bus
);
  localparam int CMD_W = 1 + CHAN_W + ADDR_W;
  localparam int SH_W  = (CMD_W > DATA_W) ? CMD_W : DATA_W;
  localparam int CNT_W = (SH_W > 1) ? $clog2(SH_W) : 1;
  localparam logic [CHAN_W:0] CHAN_LIM = (CHAN_W + 1)'(CHANNELS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  logic [1:0]        ss_sync_q, sclk_sync_q, mosi_sync_q;
  logic              ss_hist_q, sclk_hist_q;
  state_e            state_q;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [SH_W-1:0]   shift_q;
  logic              ai_q, chan_ok_q;
  logic [CHAN_W-1:0] chan_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_en_q, frame_err_q, busy_q;
  logic [CHAN_W-1:0] wr_chan_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic              sclk_rise_s, ss_rise_s, ss_fall_s, mosi_s;
  logic [SH_W-1:0]   shift_nxt_s;
  logic [CMD_W-1:0]  cmd_word_s;
  logic [CHAN_W-1:0] cmd_chan_s;
  logic              chan_ok_s, cmd_last_s, data_last_s;

  // ss resets to its idle-high level so release never fakes a frame edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ss_sync_q   <= 2'b11;
      ss_hist_q   <= 1'b1;
      sclk_sync_q <= 2'b00;
      sclk_hist_q <= 1'b0;
      mosi_sync_q <= 2'b00;
    end else begin
      ss_sync_q   <= {ss_sync_q[0], bus.ss};
      ss_hist_q   <= ss_sync_q[1];
      sclk_sync_q <= {sclk_sync_q[0], bus.sclk};
      sclk_hist_q <= sclk_sync_q[1];
      mosi_sync_q <= {mosi_sync_q[0], bus.mosi};
    end
  end

  assign sclk_rise_s = sclk_sync_q[1] & ~sclk_hist_q;
  assign ss_rise_s   = ss_sync_q[1] & ~ss_hist_q;
  assign ss_fall_s   = ~ss_sync_q[1] & ss_hist_q;
  assign mosi_s      = mosi_sync_q[1];
  assign shift_nxt_s = {shift_q[SH_W-2:0], mosi_s};
  assign cmd_word_s  = shift_nxt_s[CMD_W-1:0];
  assign cmd_chan_s  = cmd_word_s[ADDR_W +: CHAN_W];
  assign chan_ok_s   = ({1'b0, cmd_chan_s} < CHAN_LIM);
  assign cmd_last_s  = (state_q == ST_CMD) && sclk_rise_s && (bit_cnt_q == CNT_W'(CMD_W - 1));
  assign data_last_s = (state_q == ST_DATA) && sclk_rise_s && (bit_cnt_q == CNT_W'(DATA_W - 1));

  // Bit count after this cycle's shift; the frame-end check looks at this value.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (sclk_rise_s && (state_q != ST_IDLE)) begin
      if (cmd_last_s || data_last_s) begin
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end else begin
      bit_cnt_d = bit_cnt_q;
    end
  end

  // Frame FSM with registered strobes; the ss-rise branch is last so it overrides.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ai_q        <= 1'b0;
      chan_ok_q   <= 1'b0;
      chan_q      <= '0;
      addr_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_chan_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      wr_en_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= ~ss_sync_q[0];
      bit_cnt_q   <= bit_cnt_d;
      if (sclk_rise_s) begin
        shift_q <= shift_nxt_s;
      end
      case (state_q)
        ST_IDLE: begin
          bit_cnt_q <= '0;
          state_q   <= ss_fall_s ? ST_CMD : ST_IDLE;
        end
        ST_CMD: begin
          if (cmd_last_s) begin
            ai_q        <= cmd_word_s[CMD_W-1];
            chan_q      <= cmd_chan_s;
            addr_q      <= cmd_word_s[ADDR_W-1:0];
            chan_ok_q   <= chan_ok_s;
            frame_err_q <= ~chan_ok_s;
            state_q     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (data_last_s && chan_ok_q) begin
            wr_en_q   <= 1'b1;
            wr_chan_q <= chan_q;
            wr_addr_q <= addr_q;
            wr_data_q <= shift_nxt_s[DATA_W-1:0];
            if (ai_q) begin
              addr_q <= addr_q + ADDR_W'(1);
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          bit_cnt_q <= '0;
        end
      endcase
      if (ss_rise_s) begin
        state_q   <= ST_IDLE;
        bit_cnt_q <= '0;
        if (bit_cnt_d != '0) begin
          frame_err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_chan   = wr_chan_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_sid_spi_burst_rx.sv
// Self-checking bench for sid_spi_burst_rx: directed vector table, hand-written
// latency/reset sequences, and random frames against a byte-level reference model.
module tb_sid_spi_burst_rx;
  localparam int H = 3;  // clk cycles per sclk phase

  typedef struct {
    logic [31:0] frame;   // bits sent MSB first
    int          nbits;
    bit          lat;
    int          nw;
    logic [14:0] w0, w1, w2;  // {chan, addr, data}
    int          err;
  } vec_t;

  logic clk;
  logic rst_n;
  sid_spi_burst_rx_if #(.CHAN_W(2), .ADDR_W(5), .DATA_W(8)) bus ();

  sid_spi_burst_rx #(.ADDR_W(5), .DATA_W(8), .CHAN_W(2), .CHANNELS(2)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  logic [14:0] got_q[$];
  logic [14:0] exp_q[$];
  int          got_err = 0;
  int          exp_err = 0;
  int          dbl_wr = 0;
  int          dbl_fe = 0;
  logic        prev_wr = 1'b0;
  logic        prev_fe = 1'b0;
  vec_t        vecs[9];

  // Capture every write strobe and error pulse, and flag any that last two cycles.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wr_en) got_q.push_back({bus.wr_chan, bus.wr_addr, bus.wr_data});
      if (bus.frame_err) got_err <= got_err + 1;
      if (bus.wr_en && prev_wr) dbl_wr <= dbl_wr + 1;
      if (bus.frame_err && prev_fe) dbl_fe <= dbl_fe + 1;
      prev_wr <= bus.wr_en;
      prev_fe <= bus.frame_err;
    end else begin
      prev_wr <= 1'b0;
      prev_fe <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic run_frame(input logic [31:0] w, input int nbits, input bit lat);
    bus.ss   = 1'b0;
    bus.sclk = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      bus.sclk = 1'b0;
      bus.mosi = w[31-i];
      repeat (H) @(negedge clk);
      bus.sclk = 1'b1;
      if (lat && i == nbits - 1) begin
        @(posedge clk); @(posedge clk); #1;
        chk("lat_before_e2", 32'(bus.wr_en), 32'd0);
        @(posedge clk); #1;
        chk("lat_at_e2", 32'(bus.wr_en), 32'd1);
        @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
    end
    bus.sclk = 1'b0;
    repeat (H) @(negedge clk);
    bus.ss = 1'b1;
    repeat (6) @(negedge clk);
    #2;
  endtask

  // Reference: decode the frame from bytes, not from bit-serial state.
  task automatic model(input logic [31:0] w, input int nbits);
    logic [7:0] cmd, d;
    logic       ai;
    int         chan, addr, nw;
    exp_q.delete();
    exp_err = 0;
    if (nbits < 8) begin
      exp_err = (nbits != 0) ? 1 : 0;
      return;
    end
    cmd  = w[31:24];
    ai   = cmd[7];
    chan = int'(cmd[6:5]);
    addr = int'(cmd[4:0]);
    if (chan >= 2) exp_err++;
    nw = (nbits - 8) / 8;
    if ((nbits - 8) % 8 != 0) exp_err++;
    for (int k = 0; k < nw; k++) begin
      d = 8'((w >> (16 - 8 * k)) & 32'hFF);
      if (chan < 2) exp_q.push_back({2'(chan), 5'(addr), d});
      if (ai) addr = (addr + 1) % 32;
    end
  endtask

  task automatic check_frame(input string tag);
    int n;
    chk({tag, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_write%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    chk({tag, "_frame_err"}, 32'(got_err), 32'(exp_err));
    chk({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
    got_q.delete();
    got_err = 0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_wr_en"}, 32'(bus.wr_en), 32'd0);
    chk({tag, "_wr_chan"}, 32'(bus.wr_chan), 32'd0);
    chk({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(bus.wr_data), 32'd0);
    chk({tag, "_frame_err"}, 32'(bus.frame_err), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'h85112233, 32, 1'b1, 3, {2'd0, 5'd5, 8'h11}, {2'd0, 5'd6, 8'h22}, {2'd0, 5'd7, 8'h33}, 0};
    vecs[1] = '{32'h9FAABB00, 24, 1'b0, 2, {2'd0, 5'd31, 8'hAA}, {2'd0, 5'd0, 8'hBB}, 15'd0, 0};
    vecs[2] = '{32'h38010200, 24, 1'b0, 2, {2'd1, 5'd24, 8'h01}, {2'd1, 5'd24, 8'h02}, 15'd0, 0};
    vecs[3] = '{32'h40FF0000, 16, 1'b0, 0, 15'd0, 15'd0, 15'd0, 1};
    vecs[4] = '{32'h85A80000, 13, 1'b0, 0, 15'd0, 15'd0, 15'd0, 1};
    vecs[5] = '{32'h015A0000, 16, 1'b0, 1, {2'd0, 5'd1, 8'h5A}, 15'd0, 15'd0, 0};
    vecs[6] = '{32'h00000000, 0, 1'b0, 0, 15'd0, 15'd0, 15'd0, 0};
    vecs[7] = '{32'h85000000, 8, 1'b0, 0, 15'd0, 15'd0, 15'd0, 0};
    vecs[8] = '{32'hE0000000, 3, 1'b0, 0, 15'd0, 15'd0, 15'd0, 1};

    rst_n    = 1'b0;
    bus.ss   = 1'b1;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    repeat (2) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 9; v++) begin
      run_frame(vecs[v].frame, vecs[v].nbits, vecs[v].lat);
      exp_q.delete();
      if (vecs[v].nw > 0) exp_q.push_back(vecs[v].w0);
      if (vecs[v].nw > 1) exp_q.push_back(vecs[v].w1);
      if (vecs[v].nw > 2) exp_q.push_back(vecs[v].w2);
      exp_err = vecs[v].err;
      check_frame($sformatf("vec%0d", v));
    end

    // Reset in the middle of a frame: 12 bits in, then asynchronous reset.
    bus.ss   = 1'b0;
    bus.sclk = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      bus.sclk = 1'b0;
      bus.mosi = (i < 8) ? 1'(32'h85 >> (7 - i)) : 1'b0;
      repeat (H) @(negedge clk);
      bus.sclk = 1'b1;
      repeat (H) @(negedge clk);
    end
    chk("midframe_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("async_reset");
    bus.ss   = 1'b1;
    bus.sclk = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #2;
    exp_q.delete();
    exp_err = 0;
    check_frame("after_reset");
    run_frame(32'h85110000, 16, 1'b0);
    exp_q.delete();
    exp_q.push_back({2'd0, 5'd5, 8'h11});
    exp_err = 0;
    check_frame("fresh_frame");

    for (int r = 0; r < 40; r++) begin
      logic [31:0] w;
      int          nb;
      w  = $urandom;
      nb = ($urandom_range(0, 1) == 1) ? 8 * $urandom_range(1, 4) : $urandom_range(0, 32);
      run_frame(w, nb, 1'b0);
      model(w, nb);
      check_frame($sformatf("rand%0d", r));
    end

    chk("wr_en_single_cycle", 32'(dbl_wr), 32'd0);
    chk("frame_err_single_cycle", 32'(dbl_fe), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
